// File: rtl/quant_pipe_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : quant_pipe_param                                       |
// | Description : Two-stage dead-zone quantizer for DWT coefficient      |
// |               pairs. Selects a subband reciprocal step from a        |
// |               runtime-loadable 16-entry table, multiplies, rounds    |
// |               (toward zero or half away from zero) and saturates,    |
// |               with a valid/ready handshake on both sides.            |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module quant_pipe_param #(
   parameter int DW   = 16,
   parameter int SW   = 20,
   parameter int FRAC = 14,
   parameter int OW   = 17,
   parameter int NLEV = 5
) (
   input  logic          clk_qk,
   input  logic          rst,
   input  logic          rst_syn,
   input  logic          in_vld,
   output logic          in_rdy,
   input  logic [DW-1:0] in_l,
   input  logic [DW-1:0] in_h,
   input  logic [2:0]    in_level,
   input  logic          in_ce0,
   input  logic          round_mode,
   input  logic          cfg_we,
   input  logic [3:0]    cfg_addr,
   input  logic [SW-1:0] cfg_data,
   output logic          out_vld,
   input  logic          out_rdy,
   output logic [OW-1:0] out_l,
   output logic [OW-1:0] out_h,
   output logic [3:0]    out_band_l,
   output logic [3:0]    out_band_h,
   output logic          out_byp_l,
   output logic          out_sat
);

   // Product width: signed coefficient times zero-extended unsigned step.
   localparam int c_PW = DW + SW + 1;

   localparam int c_TBL_RST [16] = '{278460, 281378, 281378, 284963,
                                     139955, 139955, 140985,  68548,
                                      68548,  68165,  32720,  32720,
                                      31699,  16568,  16568,  17047};

   localparam logic signed [c_PW-1:0] c_QMAX = {{(c_PW-OW+1){1'b0}}, {(OW-1){1'b1}}};
   localparam logic signed [c_PW-1:0] c_QMIN = {{(c_PW-OW+1){1'b1}}, {(OW-1){1'b0}}};
   localparam logic signed [c_PW-1:0] c_ONE  = c_PW'(1);
   localparam logic        [c_PW-1:0] c_HALF = c_PW'(1) << (FRAC - 1);

   // Reciprocal step table
   logic [SW-1:0]          tbl_q [16];

   // Handshake
   logic                   w_adv;

   // Stage 1 next-state and registers
   logic [3:0]             w_lh;
   logic [3:0]             s1_bl_d,   s1_bl_q;
   logic [3:0]             s1_bh_d,   s1_bh_q;
   logic                   s1_bypl_d, s1_bypl_q;
   logic                   s1_byph_d, s1_byph_q;
   logic signed [c_PW-1:0] s1_pl_d,   s1_pl_q;
   logic signed [c_PW-1:0] s1_ph_d,   s1_ph_q;
   logic [DW-1:0]          s1_rl_q,   s1_rh_q;
   logic                   s1_mode_q;
   logic                   s1_vld_q;

   logic [SW-1:0]          w_step_l,  w_step_h;
   logic signed [c_PW-1:0] w_xl, w_xh, w_sl, w_sh;

   // Stage 2 next-state and registers
   logic [OW:0]            w_rl, w_rh;
   logic [OW-1:0]          out_l_d,   out_l_q;
   logic [OW-1:0]          out_h_d,   out_h_q;
   logic                   out_sat_d, out_sat_q;
   logic [3:0]             out_bl_q,  out_bh_q;
   logic                   out_byp_q;
   logic                   out_vld_q;

   // Both stages move together; an empty output slot or a taker frees the pipe.
   assign w_adv  = !out_vld_q || out_rdy;
   assign in_rdy = w_adv;

   // Step table: defaults on reset, one write port; a same-cycle read sees the old entry.
   always_ff @(posedge clk_qk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) begin
            tbl_q[i] <= SW'(c_TBL_RST[i]);
         end
      end else if (cfg_we) begin
         tbl_q[cfg_addr] <= cfg_data;
      end
   end

   // Subband routing: map level and row phase onto table indices and bypass flags.
   always_comb begin
      w_lh      = 4'(3 * (NLEV - 1 - int'(in_level)) + 1);
      s1_bl_d   = 4'd0;
      s1_bh_d   = 4'd0;
      s1_bypl_d = 1'b0;
      s1_byph_d = 1'b0;
      if (int'(in_level) >= NLEV) begin
         // Beyond the configured depth: pass both channels untouched.
         s1_bypl_d = 1'b1;
         s1_byph_d = 1'b1;
      end else if ((int'(in_level) < NLEV - 1) && (in_ce0 == ~in_level[0])) begin
         // Pass phase: LL data continues to the next level, h is LH.
         s1_bypl_d = 1'b1;
         s1_bh_d   = w_lh;
      end else if (in_ce0 && (int'(in_level) == NLEV - 1)) begin
         // Coarsest level, LL/LH row.
         s1_bh_d   = w_lh;
      end else begin
         s1_bl_d   = w_lh + 4'd1;
         s1_bh_d   = w_lh + 4'd2;
      end
   end

   assign w_step_l = tbl_q[s1_bl_d];
   assign w_step_h = tbl_q[s1_bh_d];
   assign w_xl     = {{(c_PW-DW){in_l[DW-1]}}, in_l};
   assign w_xh     = {{(c_PW-DW){in_h[DW-1]}}, in_h};
   assign w_sl     = {{(c_PW-SW){1'b0}}, w_step_l};
   assign w_sh     = {{(c_PW-SW){1'b0}}, w_step_h};
   assign s1_pl_d  = w_xl * w_sl;
   assign s1_ph_d  = w_xh * w_sh;

   // Stage 1: capture products, routing, mode and raw inputs for the bypass path.
   always_ff @(posedge clk_qk or posedge rst) begin
      if (rst) begin
         s1_vld_q  <= 1'b0;
         s1_pl_q   <= '0;
         s1_ph_q   <= '0;
         s1_rl_q   <= '0;
         s1_rh_q   <= '0;
         s1_bl_q   <= '0;
         s1_bh_q   <= '0;
         s1_bypl_q <= 1'b0;
         s1_byph_q <= 1'b0;
         s1_mode_q <= 1'b0;
      end else if (rst_syn) begin
         s1_vld_q  <= 1'b0;
         s1_pl_q   <= '0;
         s1_ph_q   <= '0;
         s1_rl_q   <= '0;
         s1_rh_q   <= '0;
         s1_bl_q   <= '0;
         s1_bh_q   <= '0;
         s1_bypl_q <= 1'b0;
         s1_byph_q <= 1'b0;
         s1_mode_q <= 1'b0;
      end else if (w_adv) begin
         s1_vld_q <= in_vld;
         if (in_vld) begin
            s1_pl_q   <= s1_pl_d;
            s1_ph_q   <= s1_ph_d;
            s1_rl_q   <= in_l;
            s1_rh_q   <= in_h;
            s1_bl_q   <= s1_bl_d;
            s1_bh_q   <= s1_bh_d;
            s1_bypl_q <= s1_bypl_d;
            s1_byph_q <= s1_byph_d;
            s1_mode_q <= round_mode;
         end
      end
   end

   // Round a scaled product to an integer and clip it to the output range.
   // Returns {clip, q}.
   function automatic logic [OW:0] f_round_sat(input logic signed [c_PW-1:0] p,
                                                input logic                   mode);
      logic signed [c_PW-1:0] q;
      logic        [c_PW-1:0] mag;
      logic                   neg;
      logic                   clip;
      q    = '0;
      mag  = '0;
      clip = 1'b0;
      neg  = p[c_PW-1];
      if (mode) begin
         // Half away from zero: round the magnitude, then restore the sign.
         mag = neg ? $unsigned(-p) : $unsigned(p);
         mag = (mag + c_HALF) >> FRAC;
         q   = neg ? -$signed(mag) : $signed(mag);
      end else begin
         // Toward zero: floor, then step back up for negatives with a fraction.
         q = p >>> FRAC;
         if (neg && (p[FRAC-1:0] != '0)) begin
            q = q + c_ONE;
         end
      end
      if (q > c_QMAX) begin
         q    = c_QMAX;
         clip = 1'b1;
      end else if (q < c_QMIN) begin
         q    = c_QMIN;
         clip = 1'b1;
      end
      return {clip, q[OW-1:0]};
   endfunction

   // Stage 2 datapath: quantize or sign-extend each channel, merge clip flags.
   always_comb begin
      w_rl      = f_round_sat(s1_pl_q, s1_mode_q);
      w_rh      = f_round_sat(s1_ph_q, s1_mode_q);
      out_l_d   = s1_bypl_q ? {{(OW-DW){s1_rl_q[DW-1]}}, s1_rl_q} : w_rl[OW-1:0];
      out_h_d   = s1_byph_q ? {{(OW-DW){s1_rh_q[DW-1]}}, s1_rh_q} : w_rh[OW-1:0];
      out_sat_d = (!s1_bypl_q && w_rl[OW]) || (!s1_byph_q && w_rh[OW]);
   end

   // Stage 2: output register, held while the consumer stalls.
   always_ff @(posedge clk_qk or posedge rst) begin
      if (rst) begin
         out_vld_q <= 1'b0;
         out_l_q   <= '0;
         out_h_q   <= '0;
         out_bl_q  <= '0;
         out_bh_q  <= '0;
         out_byp_q <= 1'b0;
         out_sat_q <= 1'b0;
      end else if (rst_syn) begin
         out_vld_q <= 1'b0;
         out_l_q   <= '0;
         out_h_q   <= '0;
         out_bl_q  <= '0;
         out_bh_q  <= '0;
         out_byp_q <= 1'b0;
         out_sat_q <= 1'b0;
      end else if (w_adv) begin
         out_vld_q <= s1_vld_q;
         if (s1_vld_q) begin
            out_l_q   <= out_l_d;
            out_h_q   <= out_h_d;
            out_bl_q  <= s1_bl_q;
            out_bh_q  <= s1_bh_q;
            out_byp_q <= s1_bypl_q;
            out_sat_q <= out_sat_d;
         end
      end
   end

   assign out_vld    = out_vld_q;
   assign out_l      = out_l_q;
   assign out_h      = out_h_q;
   assign out_band_l = out_bl_q;
   assign out_band_h = out_bh_q;
   assign out_byp_l  = out_byp_q;
   assign out_sat    = out_sat_q;

endmodule
`default_nettype wire

// File: tb/tb_quant_pipe_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_quant_pipe_param                                    |
// | Description : Self-checking bench for quant_pipe_param. Directed     |
// |               cases plus a randomized stream scored against an       |
// |               arithmetic reference model and an expected-beat queue. |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_quant_pipe_param;

   localparam int DW   = 16;
   localparam int SW   = 20;
   localparam int FRAC = 14;
   localparam int OW   = 17;
   localparam int NLEV = 5;

   localparam longint c_QMAX = (longint'(1) << (OW - 1)) - 1;
   localparam longint c_QMIN = -(longint'(1) << (OW - 1));
   localparam longint c_DIV  = longint'(1) << FRAC;
   localparam longint c_HALF = longint'(1) << (FRAC - 1);

   logic                 clk_qk = 1'b0;
   logic                 rst;
   logic                 rst_syn;
   logic                 in_vld;
   logic                 in_rdy;
   logic signed [DW-1:0] in_l;
   logic signed [DW-1:0] in_h;
   logic [2:0]           in_level;
   logic                 in_ce0;
   logic                 round_mode;
   logic                 cfg_we;
   logic [3:0]           cfg_addr;
   logic [SW-1:0]        cfg_data;
   logic                 out_vld;
   logic                 out_rdy;
   logic signed [OW-1:0] out_l;
   logic signed [OW-1:0] out_h;
   logic [3:0]           out_band_l;
   logic [3:0]           out_band_h;
   logic                 out_byp_l;
   logic                 out_sat;

   quant_pipe_param #(.DW(DW), .SW(SW), .FRAC(FRAC), .OW(OW), .NLEV(NLEV)) u_dut (
      .clk_qk     (clk_qk),
      .rst        (rst),
      .rst_syn    (rst_syn),
      .in_vld     (in_vld),
      .in_rdy     (in_rdy),
      .in_l       (in_l),
      .in_h       (in_h),
      .in_level   (in_level),
      .in_ce0     (in_ce0),
      .round_mode (round_mode),
      .cfg_we     (cfg_we),
      .cfg_addr   (cfg_addr),
      .cfg_data   (cfg_data),
      .out_vld    (out_vld),
      .out_rdy    (out_rdy),
      .out_l      (out_l),
      .out_h      (out_h),
      .out_band_l (out_band_l),
      .out_band_h (out_band_h),
      .out_byp_l  (out_byp_l),
      .out_sat    (out_sat)
   );

   always #5 clk_qk = ~clk_qk;

   typedef struct {
      longint l;
      longint h;
      int     bl;   // -1: band_l not meaningful (pass-phase bypass)
      int     bh;
      bit     byp;
      bit     sat;
   } exp_t;

   int     n_chk  = 0;
   int     n_fail = 0;
   int     tbl_m [16];
   exp_t   q_exp [$];
   bit     last_acc;
   bit     hold_pend;
   longint hold_l, hold_h;
   longint obs_l, obs_h, obs_bh, obs_byp, obs_sat;

   task automatic chk(input string tag, input logic signed [63:0] obs,
                      input logic signed [63:0] exp_v);
      n_chk++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   function automatic void tbl_defaults();
      tbl_m = '{278460, 281378, 281378, 284963, 139955, 139955, 140985, 68548,
                68548, 68165, 32720, 32720, 31699, 16568, 16568, 17047};
   endfunction

   // Quantize with ordinary integer division; SV division truncates toward zero.
   function automatic longint quant_m(input longint x, input longint step,
                                      input bit mode, output bit clip);
      longint p, m, q;
      p = x * step;
      if (!mode) begin
         q = p / c_DIV;
      end else begin
         m = ((p < 0 ? -p : p) + c_HALF) / c_DIV;
         q = (p < 0) ? -m : m;
      end
      clip = 1'b0;
      if (q > c_QMAX) begin
         q = c_QMAX; clip = 1'b1;
      end else if (q < c_QMIN) begin
         q = c_QMIN; clip = 1'b1;
      end
      return q;
   endfunction

   function automatic exp_t model(input int lev, input bit ce0, input longint l,
                                  input longint h, input bit mode);
      exp_t e;
      int   lh;
      bit   cl, ch;
      e.l = l; e.h = h; e.bl = 0; e.bh = 0; e.byp = 1'b0; e.sat = 1'b0;
      cl = 1'b0; ch = 1'b0;
      if (lev >= NLEV) begin
         e.byp = 1'b1;
      end else begin
         lh = 3 * (NLEV - 1 - lev) + 1;
         if (lev < NLEV - 1 && ce0 == (lev % 2 == 0)) begin
            e.byp = 1'b1; e.bl = -1; e.bh = lh;
         end else if (lev == NLEV - 1 && ce0) begin
            e.bl = 0; e.bh = lh;
         end else begin
            e.bl = lh + 1; e.bh = lh + 2;
         end
         if (!e.byp) e.l = quant_m(l, tbl_m[e.bl], mode, cl);
         e.h   = quant_m(h, tbl_m[e.bh], mode, ch);
         e.sat = cl | ch;
      end
      return e;
   endfunction

   // One clock: evaluate the handshakes for the current inputs, then move to the next negedge.
   task automatic tick();
      exp_t f;
      #1;
      last_acc = 1'b0;
      if (hold_pend) begin
         chk("hold_vld", out_vld, 1);
         chk("hold_l", out_l, hold_l);
         chk("hold_h", out_h, hold_h);
      end
      hold_pend = out_vld && !out_rdy && !rst_syn;
      hold_l    = out_l;
      hold_h    = out_h;
      if (out_vld && out_rdy) begin
         if (q_exp.size() == 0) begin
            chk("unexpected_beat", out_vld, 0);
         end else begin
            f       = q_exp.pop_front();
            obs_l   = out_l;
            obs_h   = out_h;
            obs_bh  = out_band_h;
            obs_byp = out_byp_l;
            obs_sat = out_sat;
            chk("out_l", obs_l, f.l);
            chk("out_h", obs_h, f.h);
            chk("band_h", obs_bh, f.bh);
            chk("byp_l", obs_byp, f.byp);
            chk("sat", obs_sat, f.sat);
            if (f.bl >= 0) chk("band_l", out_band_l, f.bl);
         end
      end
      if (rst_syn) begin
         q_exp.delete();
      end else if (in_vld && in_rdy) begin
         q_exp.push_back(model(int'(in_level), in_ce0, in_l, in_h, round_mode));
         last_acc = 1'b1;
      end
      if (cfg_we) tbl_m[cfg_addr] = int'(cfg_data);
      @(negedge clk_qk);
   endtask

   // Single beat into an empty pipe; also checks the two-cycle latency.
   task automatic send_one(input int lev, input bit ce0, input int l, input int h,
                           input bit mode);
      in_vld = 1'b1; in_level = 3'(lev); in_ce0 = ce0;
      in_l = 16'(l); in_h = 16'(h); round_mode = mode;
      out_rdy = 1'b1; rst_syn = 1'b0;
      tick();
      chk("send_acc", last_acc, 1);
      cfg_we = 1'b0; in_vld = 1'b0;
      chk("lat_s1", out_vld, 0);
      tick();
      chk("lat_s2", out_vld, 1);
      tick();
   endtask

   task automatic drain();
      in_vld = 1'b0; cfg_we = 1'b0; rst_syn = 1'b0; out_rdy = 1'b1;
      for (int k = 0; k < 20 && q_exp.size() > 0; k++) tick();
      chk("drain_empty", q_exp.size(), 0);
      repeat (3) tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired checks=%0d", n_chk);
      $fatal(1, "watchdog");
   end

   initial begin
      int idx;
      rst = 1'b1; rst_syn = 1'b0; in_vld = 1'b0; in_l = '0; in_h = '0;
      in_level = '0; in_ce0 = 1'b0; round_mode = 1'b0; cfg_we = 1'b0;
      cfg_addr = '0; cfg_data = '0; out_rdy = 1'b0; hold_pend = 1'b0;
      tbl_defaults();
      repeat (3) @(negedge clk_qk);
      rst = 1'b0;
      chk("rst_vld", out_vld, 0);
      chk("rst_l", out_l, 0);
      chk("rst_h", out_h, 0);
      chk("rst_sat", out_sat, 0);
      chk("rst_byp", out_byp_l, 0);
      chk("rst_rdy", in_rdy, 1);

      // LH of level 0
      send_one(0, 1, -1234, 100, 0);
      chk("tp_lh1_h", obs_h, 101);
      chk("tp_lh1_band", obs_bh, 13);
      chk("tp_lh1_byp", obs_byp, 1);
      chk("tp_lh1_l", obs_l, -1234);
      send_one(0, 1, 7, -100, 0);
      chk("tp_lh1_neg", obs_h, -101);

      // Rounding modes on LL
      send_one(4, 1, 1, 0, 0);  chk("tp_rnd_m0p", obs_l, 16);
      send_one(4, 1, 1, 0, 1);  chk("tp_rnd_m1p", obs_l, 17);
      send_one(4, 1, -1, 0, 0); chk("tp_rnd_m0n", obs_l, -16);
      send_one(4, 1, -1, 0, 1); chk("tp_rnd_m1n", obs_l, -17);

      // Saturation
      send_one(4, 0, 0, 32767, 0);
      chk("tp_sat_p", obs_h, 65535);  chk("tp_sat_pf", obs_sat, 1);
      send_one(4, 0, 0, -32768, 0);
      chk("tp_sat_n", obs_h, -65536); chk("tp_sat_nf", obs_sat, 1);

      // Table write coinciding with an accepted beat
      cfg_we = 1'b1; cfg_addr = 4'd13; cfg_data = 20'd32768;
      send_one(0, 1, 0, 50, 0); chk("tp_tbl_old", obs_h, 50);
      send_one(0, 1, 0, 50, 0); chk("tp_tbl_new", obs_h, 100);

      // Backpressure: three beats into a stalled consumer
      out_rdy = 1'b0; idx = 0;
      for (int k = 0; k < 10 && idx < 3; k++) begin
         in_vld = 1'b1; in_level = 3'd0; in_ce0 = 1'b1; round_mode = 1'b0;
         in_l = 16'(idx * 11 - 5); in_h = 16'((idx + 1) * 10);
         tick();
         if (last_acc) idx++;
      end
      chk("bp_accepted", idx, 2);
      chk("bp_rdy_low", in_rdy, 0);
      out_rdy = 1'b1;
      for (int k = 0; k < 10 && idx < 3; k++) begin
         tick();
         if (last_acc) idx++;
      end
      chk("bp_third", idx, 3);
      drain();

      // Randomized stream
      for (int n = 0; n < 800; n++) begin
         in_vld     = ($urandom_range(0, 3) != 0);
         in_level   = 3'($urandom_range(0, 7));
         in_ce0     = 1'($urandom);
         round_mode = 1'($urandom);
         case ($urandom_range(0, 7))
            0:       in_l = 16'sh7fff;
            1:       in_l = 16'sh8000;
            default: in_l = 16'($urandom);
         endcase
         case ($urandom_range(0, 7))
            0:       in_h = 16'sh8000;
            1:       in_h = 16'($urandom_range(0, 200)) - 16'sd100;
            default: in_h = 16'($urandom);
         endcase
         out_rdy  = ($urandom_range(0, 3) != 0);
         cfg_we   = ($urandom_range(0, 15) == 0);
         cfg_addr = 4'($urandom);
         cfg_data = 20'($urandom_range(0, 300000));
         rst_syn  = ($urandom_range(0, 63) == 0);
         tick();
      end
      drain();

      // Asynchronous reset with beats in flight
      out_rdy = 1'b0;
      in_vld = 1'b1; in_level = 3'd0; in_ce0 = 1'b1; in_l = 16'sd300; in_h = 16'sd100;
      tick(); tick();
      in_vld = 1'b0;
      chk("pre_rst_vld", out_vld, 1);
      #2 rst = 1'b1;
      #1;
      chk("arst_vld", out_vld, 0);
      chk("arst_l", out_l, 0);
      chk("arst_h", out_h, 0);
      chk("arst_bl", out_band_l, 0);
      chk("arst_bh", out_band_h, 0);
      chk("arst_byp", out_byp_l, 0);
      chk("arst_sat", out_sat, 0);
      q_exp.delete(); hold_pend = 1'b0; tbl_defaults();
      @(negedge clk_qk);
      rst = 1'b0;
      chk("arst_rdy", in_rdy, 1);
      send_one(0, 1, 0, 100, 0);
      chk("tp_rst_tbl13", obs_h, 101);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
